// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
// Imported by the lane aligner and the mem_lsu top.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RDW,
        S_DONE
    } lsu_state_t;

    function automatic int lane_offset_bits(input int xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane datapath: misalignment check, strobes, store replication
// and load extract/extend. Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OB   = lane_offset_bits(XLEN),
    parameter int NB   = XLEN / 8
) (
    input  logic [1:0]      chk_size,
    input  logic [OB-1:0]   chk_off,
    output logic            misalign,
    input  logic            we,
    input  logic [1:0]      size,
    input  logic [OB-1:0]   off,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [NB-1:0]   strb,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata_ext
);

    logic [NB-1:0]   lo_mask;
    logic [OB-1:0]   lane_mask;
    logic [OB+2:0]   sign_idx;
    logic [XLEN-1:0] shifted;
    logic            fill;

    always_comb begin
        misalign = 1'b0;
        unique case (chk_size)
            SZ_B: misalign = 1'b0;
            SZ_H: misalign = chk_off[0];
            SZ_W: misalign = (chk_off[1:0] != 2'b00);
            SZ_D: misalign = (XLEN < 64) || (chk_off != '0);
        endcase
    end

    // lane_mask wraps a destination lane onto a source byte of the access
    always_comb begin
        lo_mask   = '1;
        lane_mask = '1;
        unique case (size)
            SZ_B: begin lo_mask = NB'(1);  lane_mask = OB'(0); end
            SZ_H: begin lo_mask = NB'(3);  lane_mask = OB'(1); end
            SZ_W: begin lo_mask = NB'(15); lane_mask = OB'(3); end
            SZ_D: begin lo_mask = '1;      lane_mask = '1;     end
        endcase
    end

    assign strb = we ? (lo_mask << off) : '0;

    always_comb begin
        wdata_rep = '0;
        for (int i = 0; i < NB; i++) begin
            wdata_rep[8*i +: 8] = wdata[8*int'(OB'(i) & lane_mask) +: 8];
        end
    end

    assign shifted  = rdata >> {off, 3'b000};
    assign sign_idx = {lane_mask, 3'b111};
    assign fill     = !is_unsigned && shifted[sign_idx];

    always_comb begin
        rdata_ext = '0;
        for (int i = 0; i < XLEN; i++) begin
            rdata_ext[i] = ((OB+3)'(i) <= sign_idx) ? shifted[i] : fill;
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit between the core and data memory,
// with access and stall performance counters.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic                resp_misalign,
    output logic [XLEN-1:0]     resp_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_write,
    output logic                mem_read,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_strb,
    input  logic                mem_req_ack,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_rdata_valid,
    output logic                mem_rdata_ack,
    output logic [CNT_W-1:0]    cnt_load,
    output logic [CNT_W-1:0]    cnt_store,
    output logic [CNT_W-1:0]    cnt_stall
);

    localparam int OB = lane_offset_bits(XLEN);
    localparam int NB = XLEN / 8;

    lsu_state_t        state, state_next;
    logic              r_we, r_uns, r_mis;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic              req_mis;
    logic [NB-1:0]     strb_w;
    logic [XLEN-1:0]   load_ext;

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .chk_size    (req_size),
        .chk_off     (req_addr[OB-1:0]),
        .misalign    (req_mis),
        .we          (r_we),
        .size        (r_size),
        .off         (r_addr[OB-1:0]),
        .is_unsigned (r_uns),
        .wdata       (r_wdata),
        .rdata       (mem_rdata),
        .strb        (strb_w),
        .wdata_rep   (mem_wdata),
        .rdata_ext   (load_ext)
    );

    assign mem_addr      = {r_addr[ADDR_W-1:OB], {OB{1'b0}}};
    assign resp_misalign = resp_valid && r_mis;

    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_strb      = '0;
        mem_rdata_ack = 1'b0;
        resp_valid    = 1'b0;
        unique case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = req_mis ? S_DONE : S_REQ;
            end
            S_REQ: begin
                mem_write = r_we;
                mem_read  = !r_we;
                mem_strb  = strb_w;
                if (mem_req_ack) state_next = r_we ? S_DONE : S_RDW;
            end
            S_RDW: begin
                mem_rdata_ack = 1'b1;
                if (mem_rdata_valid) state_next = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_mis      <= 1'b0;
            r_size     <= SZ_B;
            r_addr     <= '0;
            r_wdata    <= '0;
            resp_rdata <= '0;
            cnt_load   <= '0;
            cnt_store  <= '0;
            cnt_stall  <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && req_valid) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_mis   <= req_mis;
            end
            if (state == S_RDW && mem_rdata_valid) resp_rdata <= load_ext;
            if (state == S_REQ || state == S_RDW) cnt_stall <= cnt_stall + CNT_W'(1);
            // misaligned accesses complete without being counted
            if (state == S_DONE && !r_mis) begin
                if (r_we) cnt_store <= cnt_store + CNT_W'(1);
                else      cnt_load  <= cnt_load + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a 32-bit build (4-bit counters) and a 64-bit build.
module tb_mem_lsu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
    logic [1:0]  a_req_size;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_resp_valid, a_resp_misalign;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_write, a_mem_read, a_mem_req_ack;
    logic        a_mem_rdata_valid, a_mem_rdata_ack;
    logic [3:0]  a_mem_strb, a_cnt_load, a_cnt_store, a_cnt_stall;

    // 64-bit instance
    logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr, b_mem_addr;
    logic [63:0] b_req_wdata, b_resp_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_resp_valid, b_resp_misalign;
    logic        b_mem_write, b_mem_read, b_mem_req_ack;
    logic        b_mem_rdata_valid, b_mem_rdata_ack;
    logic [7:0]  b_mem_strb;
    logic [31:0] b_cnt_load, b_cnt_store, b_cnt_stall;

    mem_lsu #(.XLEN(32), .ADDR_W(32), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_size(a_req_size),
        .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_misalign(a_resp_misalign),
        .resp_rdata(a_resp_rdata),
        .mem_addr(a_mem_addr), .mem_write(a_mem_write),
        .mem_read(a_mem_read), .mem_wdata(a_mem_wdata),
        .mem_strb(a_mem_strb), .mem_req_ack(a_mem_req_ack),
        .mem_rdata(a_mem_rdata), .mem_rdata_valid(a_mem_rdata_valid),
        .mem_rdata_ack(a_mem_rdata_ack),
        .cnt_load(a_cnt_load), .cnt_store(a_cnt_store),
        .cnt_stall(a_cnt_stall)
    );

    mem_lsu #(.XLEN(64), .ADDR_W(32), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_size(b_req_size),
        .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_misalign(b_resp_misalign),
        .resp_rdata(b_resp_rdata),
        .mem_addr(b_mem_addr), .mem_write(b_mem_write),
        .mem_read(b_mem_read), .mem_wdata(b_mem_wdata),
        .mem_strb(b_mem_strb), .mem_req_ack(b_mem_req_ack),
        .mem_rdata(b_mem_rdata), .mem_rdata_valid(b_mem_rdata_valid),
        .mem_rdata_ack(b_mem_rdata_ack),
        .cnt_load(b_cnt_load), .cnt_store(b_cnt_store),
        .cnt_stall(b_cnt_stall)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // memory model for the 32-bit instance
    int          a_delay = 0;
    logic [31:0] a_word = '0;
    int          a_seen = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_strb;
    logic        cap_we;

    initial begin
        int rd_cnt;
        rd_cnt = 0;
        a_mem_req_ack = 1'b0;
        a_mem_rdata_valid = 1'b0;
        a_mem_rdata = '0;
        forever begin
            @(negedge clk);
            a_mem_req_ack = 1'b0;
            a_mem_rdata_valid = 1'b0;
            a_mem_rdata = a_word;
            if (rst) begin
                rd_cnt = 0;
            end else if (a_mem_read || a_mem_write) begin
                a_mem_req_ack = 1'b1;
                a_seen++;
                cap_addr  = a_mem_addr;
                cap_wdata = a_mem_wdata;
                cap_strb  = a_mem_strb;
                cap_we    = a_mem_write;
                rd_cnt    = 0;
            end else if (a_mem_rdata_ack) begin
                if (rd_cnt >= a_delay) a_mem_rdata_valid = 1'b1;
                rd_cnt++;
            end
        end
    end

    // memory model for the 64-bit instance: zero wait
    logic [63:0] b_word = 64'h0123_4567_89AB_CDEF;
    logic [31:0] bcap_addr;
    logic [63:0] bcap_wdata;
    logic [7:0]  bcap_strb;

    initial begin
        b_mem_req_ack = 1'b0;
        b_mem_rdata_valid = 1'b0;
        b_mem_rdata = '0;
        forever begin
            @(negedge clk);
            b_mem_req_ack = !rst && (b_mem_read || b_mem_write);
            b_mem_rdata_valid = !rst && b_mem_rdata_ack;
            b_mem_rdata = b_word;
            if (b_mem_read || b_mem_write) begin
                bcap_addr  = b_mem_addr;
                bcap_wdata = b_mem_wdata;
                bcap_strb  = b_mem_strb;
            end
        end
    end

    // scoreboard for the 32-bit instance
    typedef struct {
        logic        mis;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } sb_t;
    sb_t sbq[$];

    initial forever begin
        sb_t e;
        @(negedge clk);
        if (a_resp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_resp", 64'(a_resp_valid), 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("resp_misalign", 64'(a_resp_misalign), 64'(e.mis));
                chk("resp_rdata", 64'(a_resp_rdata), 64'(e.rdata));
                chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        int          delay;
        logic        mis;
        logic [31:0] maddr;
        logic [3:0]  strb;
        logic [31:0] mwdata;
        logic [31:0] rdata;
    } vec_t;
    vec_t vt[12];

    logic [31:0] m_last = '0;
    logic [3:0]  m_ld = '0, m_st = '0, m_stall = '0;

    task automatic a_access(input vec_t v);
        sb_t e;
        int  n;
        a_delay = v.delay;
        a_word  = v.word;
        a_seen  = 0;
        n = 0;
        while (!a_req_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!a_req_ready) chk("ready_timeout", 64'(a_req_ready), 64'd1);
        a_req_we       = v.we;
        a_req_size     = v.size;
        a_req_unsigned = v.uns;
        a_req_addr     = v.addr;
        a_req_wdata    = v.wdata;
        a_req_valid    = 1'b1;
        if (!v.mis && !v.we) m_last = v.rdata;
        e.mis   = v.mis;
        e.rdata = m_last;
        e.acc   = cyc;
        e.lat   = v.mis ? 1 : (v.we ? 2 : 3 + v.delay);
        sbq.push_back(e);
        if (!v.mis) begin
            if (v.we) begin
                m_st    = m_st + 4'd1;
                m_stall = m_stall + 4'd1;
            end else begin
                m_ld    = m_ld + 4'd1;
                m_stall = m_stall + 4'(2 + v.delay);
            end
        end
        @(negedge clk); #1;
        a_req_valid = 1'b0;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) begin
            chk("resp_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
        @(negedge clk); #1;
        chk("cnt_load", 64'(a_cnt_load), 64'(m_ld));
        chk("cnt_store", 64'(a_cnt_store), 64'(m_st));
        chk("cnt_stall", 64'(a_cnt_stall), 64'(m_stall));
        if (v.mis) begin
            chk("no_mem_req", 64'(a_seen), 64'd0);
        end else begin
            chk("mem_addr", 64'(cap_addr), 64'(v.maddr));
            chk("mem_strb", 64'(cap_strb), 64'(v.strb));
            chk("mem_write", 64'(cap_we), 64'(v.we));
            if (v.we) chk("mem_wdata", 64'(cap_wdata), 64'(v.mwdata));
        end
    endtask

    task automatic b_access(input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr,
                            input logic [63:0] wdata, input logic mis,
                            input logic [7:0] strb, input logic [63:0] mwdata,
                            input logic [63:0] rdata);
        int n;
        n = 0;
        while (!b_req_ready && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        b_req_we       = we;
        b_req_size     = size;
        b_req_unsigned = uns;
        b_req_addr     = addr;
        b_req_wdata    = wdata;
        b_req_valid    = 1'b1;
        @(negedge clk);
        n = 0;
        while (!b_resp_valid && n < 50) begin
            if (n == 0) begin #1; b_req_valid = 1'b0; end
            @(negedge clk);
            n++;
        end
        b_req_valid = 1'b0;
        if (!b_resp_valid) begin
            chk("b_resp_timeout", 64'(b_resp_valid), 64'd1);
        end else begin
            chk("b_misalign", 64'(b_resp_misalign), 64'(mis));
            chk("b_rdata", b_resp_rdata, rdata);
            if (!mis) begin
                chk("b_mem_addr", 64'(bcap_addr), 64'(addr & 32'hFFFF_FFF8));
                chk("b_mem_strb", 64'(bcap_strb), 64'(strb));
                if (we) chk("b_mem_wdata", bcap_wdata, mwdata);
            end
        end
        #1;
    endtask

    initial begin
        vec_t vw;
        int   n;
        // we size uns addr wdata word delay mis maddr strb mwdata rdata
        vt[0]  = '{1'b1, 2'd0, 1'b0, 32'h1003, 32'h0000_00AB, 32'h0, 0,
                   1'b0, 32'h1000, 4'b1000, 32'hABAB_ABAB, 32'h0};
        vt[1]  = '{1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 3,
                   1'b0, 32'h2000, 4'b0000, 32'h0, 32'hFFFF_8001};
        vt[2]  = '{1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 0,
                   1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
        vt[3]  = '{1'b1, 2'd1, 1'b0, 32'h1002, 32'h1234_BEEF, 32'h0, 0,
                   1'b0, 32'h1000, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vt[4]  = '{1'b1, 2'd2, 1'b0, 32'h1004, 32'hDEAD_BEEF, 32'h0, 0,
                   1'b0, 32'h1004, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vt[5]  = '{1'b0, 2'd0, 1'b1, 32'h2001, 32'h0, 32'h0000_F200, 0,
                   1'b0, 32'h2000, 4'b0000, 32'h0, 32'h0000_00F2};
        vt[6]  = '{1'b0, 2'd0, 1'b0, 32'h2001, 32'h0, 32'h0000_F200, 1,
                   1'b0, 32'h2000, 4'b0000, 32'h0, 32'hFFFF_FFF2};
        vt[7]  = '{1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 32'h8001_1234, 0,
                   1'b0, 32'h2000, 4'b0000, 32'h0, 32'h0000_8001};
        vt[8]  = '{1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 32'h89AB_CDEF, 2,
                   1'b0, 32'h2000, 4'b0000, 32'h0, 32'h89AB_CDEF};
        vt[9]  = '{1'b1, 2'd3, 1'b0, 32'h1000, 32'h1111_2222, 32'h0, 0,
                   1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
        vt[10] = '{1'b1, 2'd1, 1'b0, 32'h1001, 32'h0000_5555, 32'h0, 0,
                   1'b1, 32'h0, 4'b0000, 32'h0, 32'h0};
        vt[11] = '{1'b0, 2'd0, 1'b0, 32'h2003, 32'h0, 32'h7F00_0000, 0,
                   1'b0, 32'h2000, 4'b0000, 32'h0, 32'h0000_007F};

        rst = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = 2'd0;
        a_req_unsigned = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'd0;
        b_req_unsigned = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(a_req_ready), 64'd1);
        chk("rst_handshakes", 64'({a_resp_valid, a_resp_misalign, a_mem_read,
            a_mem_write, a_mem_rdata_ack, a_mem_strb}), 64'd0);
        chk("rst_rdata", 64'(a_resp_rdata), 64'd0);
        chk("rst_counters", 64'({a_cnt_load, a_cnt_store, a_cnt_stall}), 64'd0);
        chk("b_rst_ready", 64'(b_req_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk); #1;

        for (int i = 0; i < 12; i++) a_access(vt[i]);

        // abort a load that is waiting for read data
        a_delay = 1000;
        a_req_we = 1'b0; a_req_size = 2'd2; a_req_unsigned = 1'b0;
        a_req_addr = 32'h2000; a_req_valid = 1'b1;
        @(negedge clk); #1;
        a_req_valid = 1'b0;
        n = 0;
        while (!a_mem_rdata_ack && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("abort_in_rdw", 64'(a_mem_rdata_ack), 64'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", 64'(a_req_ready), 64'd1);
        chk("abort_rdata_ack", 64'(a_mem_rdata_ack), 64'd0);
        chk("abort_stall_clr", 64'(a_cnt_stall), 64'd0);
        m_ld = '0; m_st = '0; m_stall = '0; m_last = '0;
        repeat (5) @(negedge clk);
        #1;
        a_access(vt[4]);

        // drive cnt_load up to its wrap point
        vw = vt[8];
        vw.delay = 0;
        n = 0;
        while (m_ld != 4'd15 && n < 20) begin
            a_access(vw);
            n++;
        end
        chk("cnt_load_full", 64'(a_cnt_load), 64'd15);
        a_access(vw);
        chk("cnt_load_wrap", 64'(a_cnt_load), 64'd0);

        // 64-bit datapath
        b_access(1'b0, 2'd3, 1'b0, 32'h4008, 64'h0, 1'b0, 8'h00, 64'h0,
                 64'h0123_4567_89AB_CDEF);
        b_access(1'b0, 2'd0, 1'b1, 32'h400F, 64'h0, 1'b0, 8'h00, 64'h0,
                 64'h0000_0000_0000_0001);
        b_access(1'b0, 2'd0, 1'b0, 32'h4008, 64'h0, 1'b0, 8'h00, 64'h0,
                 64'hFFFF_FFFF_FFFF_FFEF);
        b_access(1'b0, 2'd1, 1'b0, 32'h400C, 64'h0, 1'b0, 8'h00, 64'h0,
                 64'h0000_0000_0000_4567);
        b_access(1'b1, 2'd2, 1'b0, 32'h4014, 64'h0000_0000_CAFE_F00D, 1'b0,
                 8'hF0, 64'hCAFE_F00D_CAFE_F00D, 64'h0000_0000_0000_4567);
        b_access(1'b1, 2'd3, 1'b0, 32'h4010, 64'h1122_3344_5566_7788, 1'b0,
                 8'hFF, 64'h1122_3344_5566_7788, 64'h0000_0000_0000_4567);
        b_access(1'b0, 2'd3, 1'b0, 32'h4004, 64'h0, 1'b1, 8'h00, 64'h0,
                 64'h0000_0000_0000_4567);
        chk("b_cnt_load", 64'(b_cnt_load), 64'd4);
        chk("b_cnt_store", 64'(b_cnt_store), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got cycle %0d want finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Parametrised load/store unit that owns the data-memory request and response channels on behalf of a multi-cycle RISC-V core.
- Accepts one access at a time from the core over a valid/ready interface.
- Generates byte strobes, replicated write data and sign- or zero-extended load results for a 32- or 64-bit datapath.
- Flags misaligned accesses without touching memory, and keeps access and stall performance counters.

Parameters:
- XLEN, 32, datapath and memory data width; legal values are 32 and 64.
- ADDR_W, 32, address width.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core presents an access
- req_ready  out  1  unit can accept an access
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- req_unsigned  in  1  zero-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, value in the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_misalign  out  1  completed access was misaligned
- resp_rdata  out  XLEN  extended load result
- mem_addr  out  ADDR_W  address aligned to XLEN/8 bytes
- mem_write  out  1  store request
- mem_read  out  1  load request
- mem_wdata  out  XLEN  lane-replicated store data
- mem_strb  out  XLEN/8  byte-lane enables
- mem_req_ack  in  1  memory accepts the request
- mem_rdata  in  XLEN  read data
- mem_rdata_valid  in  1  read data present
- mem_rdata_ack  out  1  unit accepts read data
- cnt_load  out  CNT_W  completed aligned loads
- cnt_store  out  CNT_W  completed aligned stores
- cnt_stall  out  CNT_W  cycles spent in REQ or RDW

Behaviour:
- Reset (rst, synchronous, active-high; clock clk):
  - State goes to IDLE.
  - All counters, resp_rdata and resp_misalign clear to 0.
  - All strobes and handshake outputs are 0, except req_ready, which is 1 because the state is IDLE.
- FSM states are IDLE, REQ, RDW and DONE. Outputs are a function of state and latched request registers only; no input-to-output combinational path except the ack-gated transitions.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we, size, unsigned, addr and wdata.
  - If misaligned, go to DONE with misalign flag set; otherwise go to REQ.
- Misalignment rules:
  - size 1 requires addr[0] = 0.
  - size 2 requires addr[1:0] = 0.
  - size 3 requires addr[2:0] = 0 and XLEN = 64; with XLEN = 32, size 3 is always misaligned.
- REQ:
  - mem_write = we, mem_read = !we.
  - mem_addr = addr with the low log2(XLEN/8) bits zeroed.
  - mem_strb = ((1 << 2^size) - 1) << offset, where offset is the low log2(XLEN/8) address bits; mem_strb = 0 for loads.
  - mem_wdata = the low 2^size bytes of wdata replicated across all lanes.
  - Request held stable until mem_req_ack. On ack, a store goes to DONE and a load goes to RDW.
- RDW:
  - mem_rdata_ack = 1.
  - On mem_rdata_valid, capture (mem_rdata >> 8*offset), truncate to 2^size bytes, and extend to XLEN (sign unless unsigned; size 3 on XLEN = 64 takes the full word).
  - Go to DONE.
- DONE:
  - resp_valid = 1 for exactly one cycle, resp_misalign = latched flag; go to IDLE.
  - resp_rdata holds its value until the next load completion. Stores and misaligned accesses leave it unchanged.
- Latency from the accept cycle T, with zero-wait memory:
  - store: resp_valid at T+2
  - load: resp_valid at T+3
  - misaligned: resp_valid at T+1
  - Back-to-back accesses are accepted at the earliest one cycle after DONE.
- Counters:
  - cnt_load / cnt_store increment in DONE for aligned accesses only.
  - cnt_stall increments in every cycle spent in REQ or RDW, including the ack cycle.
  - All counters wrap modulo 2^CNT_W.
- Reset mid-operation aborts the transaction; no resp_valid is produced. Memory outstanding-data cleanup is the system's responsibility.
- req_valid while not in IDLE is ignored; the core must hold it until accepted.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D
  - state enum
  - function lane_offset_bits(XLEN)
- Sub-module lsu_lane_align (combinational, parametrised by XLEN) computes:
  - misalign
  - mem_strb
  - mem_wdata replication
  - load extract/extend
- FSM and counters live in mem_lsu.

Test Plan:
- XLEN=32, store byte, addr 0x1003, wdata 0xAB, ack immediately → mem_addr 0x1000, strb 4'b1000, wdata 0xABABABAB, resp_valid at T+2, cnt_store = 1.
- XLEN=32, lh signed at 0x2002, mem_rdata 0x8001_1234 after 3-cycle valid delay → resp_rdata 0xFFFF8001, cnt_stall = 5 (REQ 1 + RDW 4).
- XLEN=32, lw at 0x3001 → no mem_read ever asserted, resp_valid at T+1 with resp_misalign = 1, counters unchanged.
- XLEN=64, ld at 0x4008, mem_rdata 0x0123_4567_89AB_CDEF → strb 0, resp_rdata 0x0123456789ABCDEF; lbu at 0x400F on same data → 0x01.
- Load in RDW, rst pulsed one cycle → state IDLE, req_ready = 1, no resp_valid; next store completes normally.
- Preload cnt_load to 2^CNT_W - 1 via 2^CNT_W - 1 loads (CNT_W=4 build), one more load → cnt_load wraps to 0.
